// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Bit counter must be able to hold WIDTH after the final increment.
  function automatic int cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit dataflow full adder; the only arithmetic cell used by the serial adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell processes the operands LSB-first, one bit per clock,
// framed by a start/busy/done handshake. {cout,sum} = a + b + cin.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_shift;
  logic [1:0]       w_state_nxt;
  logic             w_unused_acc0;

  fa_bit u_fa (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .cin   (r_carry),
    .sum   (w_s),
    .carry (w_co)
  );

  assign w_last = (r_cnt == LAST);

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the result sits at acc[0].
  if (WIDTH == 1) begin : g_acc_w1
    assign w_acc_shift = w_s;
  end else begin : g_acc_wn
    assign w_acc_shift = {w_s, r_acc[WIDTH-1:1]};
  end

  assign w_unused_acc0 = r_acc[0];

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = start  ? S_RUN  : S_IDLE;
      S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_acc   <= w_acc_shift;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_sum  <= w_acc_shift;
            r_cout <= w_co;
            r_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8, 1 and 13.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start1, cin1, busy1, done1, cout1;
  logic [0:0]  a1, b1, sum1;
  logic        start13, cin13, busy13, done13, cout13;
  logic [12:0] a13, b13, sum13;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  serial_adder_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [8:0]  q8[$];
  logic [1:0]  q1[$];
  logic [13:0] q13[$];
  logic        pd8 = 1'b0, pd1 = 1'b0, pd13 = 1'b0;

  always @(negedge clk) begin
    if (done8) begin
      check_eq("done8_pulse_width", pd8, 0);
      check_eq("done8_queued", q8.size() != 0, 1);
      if (q8.size() != 0) check_eq("result8", {cout8, sum8}, q8.pop_front());
    end
    if (done1) begin
      check_eq("done1_pulse_width", pd1, 0);
      check_eq("done1_queued", q1.size() != 0, 1);
      if (q1.size() != 0) check_eq("result1", {cout1, sum1}, q1.pop_front());
    end
    if (done13) begin
      check_eq("done13_pulse_width", pd13, 0);
      check_eq("done13_queued", q13.size() != 0, 1);
      if (q13.size() != 0) check_eq("result13", {cout13, sum13}, q13.pop_front());
    end
    pd8  <= done8;
    pd1  <= done1;
    pd13 <= done13;
  end

  task automatic wait_idle8();
    for (int i = 0; i < 40 && busy8; i++) @(negedge clk);
    check_eq("idle8_wait", busy8, 0);
  endtask

  // One WIDTH=8 operation; returns accept-to-done latency and number of busy cycles.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     output int lat, output int bcyc);
    wait_idle8();
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back(9'(a) + 9'(b) + 9'(c));
    lat = 0; bcyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
      lat++;
      if (busy8) bcyc++;
      if (done8) break;
    end
    lat = lat - 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy8) break;
      bcyc++;
    end
    check_eq("sum8_held", {cout8, sum8}, 9'(a) + 9'(b) + 9'(c));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcyc, cnt;
    rst_n = 1'b0;
    start8 = 0;  a8 = 0;  b8 = 0;  cin8 = 0;
    start1 = 0;  a1 = 0;  b1 = 0;  cin1 = 0;
    start13 = 0; a13 = 0; b13 = 0; cin13 = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy8", busy8, 0);
    check_eq("rst_done8", done8, 0);
    check_eq("rst_sum8", {cout8, sum8}, 0);
    check_eq("rst_busy1", busy1, 0);
    check_eq("rst_busy13", busy13, 0);
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'h3C, 8'h5A, 1'b0, lat, bcyc);
    check_eq("lat8_basic", lat, 8);
    check_eq("busy8_cycles", bcyc, 9);
    op8(8'hFF, 8'h01, 1'b0, lat, bcyc);
    check_eq("lat8_ripple", lat, 8);
    op8(8'hFF, 8'hFF, 1'b1, lat, bcyc);
    check_eq("lat8_allones", lat, 8);

    // Start pulsed mid-RUN is ignored; a start held high is taken on the first IDLE cycle.
    wait_idle8();
    a8 = 8'h10; b8 = 8'h20; cin8 = 0; start8 = 1;
    q8.push_back(9'h030);
    @(negedge clk); start8 = 0; a8 = 0; b8 = 0;
    check_eq("busy8_after_accept", busy8, 1);
    repeat (2) @(negedge clk);
    start8 = 1; a8 = 8'h01; b8 = 8'h01;
    @(negedge clk); start8 = 0;
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; cin8 = 1; start8 = 1;
    q8.push_back(9'h089);
    for (int i = 0; i < 40 && !done8; i++) @(negedge clk);
    check_eq("done8_first", done8, 1);
    @(negedge clk);
    check_eq("gap_busy8", busy8, 0);
    check_eq("gap_done8", done8, 0);
    @(negedge clk);
    check_eq("reaccept_busy8", busy8, 1);
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    wait_idle8();

    // Reset in the middle of RUN discards the operation.
    a8 = 8'hC3; b8 = 8'h3C; cin8 = 1; start8 = 1;
    @(negedge clk); start8 = 0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_busy8", busy8, 0);
    check_eq("midrst_done8", done8, 0);
    check_eq("midrst_sum8", {cout8, sum8}, 0);
    cnt = 0;
    repeat (14) begin
      @(negedge clk);
      if (done8) cnt++;
    end
    check_eq("midrst_no_done8", cnt, 0);

    // WIDTH=1 exhaustive.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      for (int k = 0; k < 10 && busy1; k++) @(negedge clk);
      a1 = v[0]; b1 = v[1]; cin1 = v[2]; start1 = 1;
      q1.push_back(2'(v[0]) + 2'(v[1]) + 2'(v[2]));
      lat = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        start1 = 0; a1 = ~v[0]; b1 = ~v[1]; cin1 = ~v[2];
        lat++;
        if (done1) break;
      end
      check_eq("lat1", lat - 1, 1);
    end

    // Random back-to-back, WIDTH=8.
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 40 && busy8; k++) @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      start8 = 1;
      q8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
      @(negedge clk);
      start8 = 0;
      check_eq("rand8_accept", busy8, 1);
    end

    // Random back-to-back, WIDTH=13.
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 40 && busy13; k++) @(negedge clk);
      a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
      start13 = 1;
      q13.push_back(14'(a13) + 14'(b13) + 14'(cin13));
      @(negedge clk);
      start13 = 0;
      check_eq("rand13_accept", busy13, 1);
    end

    for (int k = 0; k < 60 && (busy8 || busy13 || busy1); k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_eq("q8_drained", q8.size(), 0);
    check_eq("q1_drained", q1.size(), 0);
    check_eq("q13_drained", q13.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
